// File: rtl/md4_iter_core.sv
// ---------------------------------------------------------------------------
// md4_iter_core
//
// Iterative MD4 compression core. One 512-bit message block is compressed
// per operation. The 48 MD4 steps are evaluated STEPS_PER_CYCLE at a time,
// so the datapath depth scales with the parameter. The chaining value comes
// either from the MD4 IV or from chain_in, which allows multi-block messages.
//
// Parameters
//   STEPS_PER_CYCLE : MD4 steps evaluated per clock (1, 2, 4, 8 or 16)
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request a compression, accepted only while ready = 1
//   init_sel : 1 selects the MD4 IV as chaining value, 0 selects chain_in
//   block_in : message block, word i = block_in[32i+31:32i]
//   chain_in : chaining value packed {d,c,b,a}
//   ready    : core idle, a start will be accepted
//   busy     : compression in progress (ready = ~busy)
//   done     : one-cycle pulse, digest has just been updated
//   digest   : result packed {d,c,b,a}, held until the next done
// ---------------------------------------------------------------------------
module md4_iter_core #(
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         init_sel,
   input  logic [511:0] block_in,
   input  logic [127:0] chain_in,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [127:0] digest
);

   localparam int         S      = STEPS_PER_CYCLE;
   localparam logic [5:0] S6     = 6'(S);
   // Value of t in the last RUN cycle: steps 48-S .. 47 are applied there.
   localparam logic [5:0] LAST_T = 6'(48 - S);

   localparam logic [127:0] MD4_IV = 128'h10325476_98badcfe_efcdab89_67452301;

   // S must divide 16 so a single cycle never straddles two rounds.
   if (!(S == 1 || S == 2 || S == 4 || S == 8 || S == 16)) begin : g_bad_steps
      $error("md4_iter_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FINAL = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // MD4 step helpers, all indexed by the 6-bit step number t (0..47)
   // ------------------------------------------------------------------------

   // Constant-per-step left rotate; {x,x} << s leaves rotl(x,s) in the top half.
   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
      logic [63:0] w;
      w = {x, x} << s;
      return w[63:32];
   endfunction

   function automatic logic [4:0] shift_amt(input logic [5:0] t);
      logic [4:0] s;
      case (t[5:4])
         2'd0: case (t[1:0])
                  2'd0:    s = 5'd3;
                  2'd1:    s = 5'd7;
                  2'd2:    s = 5'd11;
                  default: s = 5'd19;
               endcase
         2'd1: case (t[1:0])
                  2'd0:    s = 5'd3;
                  2'd1:    s = 5'd5;
                  2'd2:    s = 5'd9;
                  default: s = 5'd13;
               endcase
         default: case (t[1:0])
                  2'd0:    s = 5'd3;
                  2'd1:    s = 5'd9;
                  2'd2:    s = 5'd11;
                  default: s = 5'd15;
               endcase
      endcase
      return s;
   endfunction

   // Message word order: round 1 linear, round 2 is the 4x4 transpose
   // (k = 4*(j%4) + j/4), round 3 is the 4-bit bit-reversal of j.
   function automatic logic [3:0] msg_idx(input logic [5:0] t);
      logic [3:0] j;
      logic [3:0] k;
      j = t[3:0];
      case (t[5:4])
         2'd0:    k = j;
         2'd1:    k = {j[1:0], j[3:2]};
         default: k = {j[0], j[1], j[2], j[3]};
      endcase
      return k;
   endfunction

   function automatic logic [31:0] round_f(input logic [1:0] r, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
      logic [31:0] f;
      case (r)
         2'd0:    f = (b & c) | (~b & d);
         2'd1:    f = (b & c) | (b & d) | (c & d);
         default: f = b ^ c ^ d;
      endcase
      return f;
   endfunction

   function automatic logic [31:0] round_k(input logic [1:0] r);
      logic [31:0] k;
      case (r)
         2'd0:    k = 32'h0000_0000;
         2'd1:    k = 32'h5a82_7999;
         default: k = 32'h6ed9_eba1;
      endcase
      return k;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [5:0]    t_q, t_d;
   logic          done_q, done_d;
   logic [127:0]  digest_q, digest_d;

   logic [31:0]   a_q, b_q, c_q, d_q;
   logic [31:0]   a_d, b_d, c_d, d_d;
   logic [31:0]   oa_q, ob_q, oc_q, od_q;
   logic [31:0]   oa_d, ob_d, oc_d, od_d;
   logic [31:0]   x_q [16];
   logic [31:0]   x_d [16];

   always_comb begin : next_state
      logic [127:0] cv;
      logic [31:0]  sa, sb, sc, sd, sn;
      logic [5:0]   st;

      state_d  = state_q;
      t_d      = t_q;
      done_d   = 1'b0;
      digest_d = digest_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      d_d      = d_q;
      oa_d     = oa_q;
      ob_d     = ob_q;
      oc_d     = oc_q;
      od_d     = od_q;
      x_d      = x_q;

      cv = init_sel ? MD4_IV : chain_in;

      // S steps chained combinationally. After each step the registers
      // rotate (a,b,c,d) <- (d,new,b,c), so the next step always finds its
      // target in 'a'. 48 steps is a whole number of rotations, so the
      // working set is back in natural order when FINAL is reached.
      sa = a_q;
      sb = b_q;
      sc = c_q;
      sd = d_q;
      sn = '0;
      st = t_q;
      for (int i = 0; i < S; i++) begin
         st = t_q + 6'(i);
         sn = rotl32(sa + round_f(st[5:4], sb, sc, sd) + x_q[msg_idx(st)]
                     + round_k(st[5:4]), shift_amt(st));
         sa = sd;
         sd = sc;
         sc = sb;
         sb = sn;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               t_d     = '0;
               for (int w = 0; w < 16; w++) begin
                  x_d[w] = block_in[32*w +: 32];
               end
               a_d  = cv[31:0];
               b_d  = cv[63:32];
               c_d  = cv[95:64];
               d_d  = cv[127:96];
               oa_d = cv[31:0];
               ob_d = cv[63:32];
               oc_d = cv[95:64];
               od_d = cv[127:96];
            end
         end
         RUN: begin
            a_d = sa;
            b_d = sb;
            c_d = sc;
            d_d = sd;
            t_d = t_q + S6;
            if (t_q == LAST_T) begin
               state_d = FINAL;
            end
         end
         FINAL: begin
            digest_d = {d_q + od_q, c_q + oc_q, b_q + ob_q, a_q + oa_q};
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control and visible result: cleared by reset so an abort leaves
   // done = 0 and digest = 0.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         t_q      <= '0;
         done_q   <= 1'b0;
         digest_q <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         done_q   <= done_d;
         digest_q <= digest_d;
      end
   end

   // ------------------------------------------------------------------------
   // Working data: always loaded on accept before use, so no reset needed.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      d_q  <= d_d;
      oa_q <= oa_d;
      ob_q <= ob_d;
      oc_q <= oc_d;
      od_q <= od_d;
      x_q  <= x_d;
   end

   assign busy   = (state_q != IDLE);
   assign ready  = ~busy;
   assign done   = done_q;
   assign digest = digest_q;

endmodule

// File: tb/tb_md4_iter_core.sv
// ---------------------------------------------------------------------------
// tb_md4_iter_core
//
// Self-checking bench for md4_iter_core. One core per legal STEPS_PER_CYCLE
// value (1,2,4,8,16) shares clock, reset and data inputs; each has its own
// start. Expected digests come from a textbook MD4 compression function
// written over an array of four chaining words.
// ---------------------------------------------------------------------------
module tb_md4_iter_core;

   localparam logic [127:0] IV = 128'h10325476_98badcfe_efcdab89_67452301;

   localparam int KORD [3][16] = '{
      '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
      '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15},
      '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15}
   };
   localparam int SHIFTS [3][4] = '{
      '{3, 7, 11, 19},
      '{3, 5, 9, 13},
      '{3, 9, 11, 15}
   };
   localparam int unsigned KCONST [3] = '{32'h0, 32'h5a827999, 32'h6ed9eba1};

   logic         clk = 1'b0;
   logic         rst;
   logic         init_sel;
   logic [511:0] block_in;
   logic [127:0] chain_in;
   logic [4:0]   start_v;
   logic [4:0]   ready_v;
   logic [4:0]   busy_v;
   logic [4:0]   done_v;
   logic [127:0] dig_v [5];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      md4_iter_core #(.STEPS_PER_CYCLE(1 << g)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .start    (start_v[g]),
         .init_sel (init_sel),
         .block_in (block_in),
         .chain_in (chain_in),
         .ready    (ready_v[g]),
         .busy     (busy_v[g]),
         .done     (done_v[g]),
         .digest   (dig_v[g])
      );
   end

   // Reference MD4 compression: h[0..3] = a,b,c,d; step i updates h[p]
   // with p walking a,d,c,b and the other three taken in cyclic order.
   function automatic logic [127:0] md4_ref(input logic [511:0] blk, input logic [127:0] cv);
      int unsigned h [4];
      int unsigned oh [4];
      int unsigned x [16];
      int unsigned f, sum, b, c, d;
      int          r, j, p, s;
      for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
      for (int i = 0; i < 4; i++) begin
         h[i]  = cv[32*i +: 32];
         oh[i] = h[i];
      end
      for (int i = 0; i < 48; i++) begin
         r = i / 16;
         j = i % 16;
         p = (4 - (i % 4)) % 4;
         b = h[(p + 1) % 4];
         c = h[(p + 2) % 4];
         d = h[(p + 3) % 4];
         if (r == 0)      f = (b & c) | (~b & d);
         else if (r == 1) f = (b & c) | (b & d) | (c & d);
         else             f = b ^ c ^ d;
         sum  = h[p] + f + x[KORD[r][j]] + KCONST[r];
         s    = SHIFTS[r][i % 4];
         h[p] = (sum << s) | (sum >> (32 - s));
      end
      return {h[3] + oh[3], h[2] + oh[2], h[1] + oh[1], h[0] + oh[0]};
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: requests an operation on core d, scrambles the
   // data inputs right after the accept edge, and returns at the negedge on
   // which done is seen (lat = clock edges after the accept edge).
   task automatic run_op(input int d, input logic [511:0] blk, input logic isel,
                         input logic [127:0] cv, output logic [127:0] dg, output int lat);
      chk("ready_at_start", 128'(ready_v[d]), 128'(1));
      block_in   = blk;
      init_sel   = isel;
      chain_in   = cv;
      start_v[d] = 1'b1;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      block_in   = rnd512();
      chain_in   = {$urandom, $urandom, $urandom, $urandom};
      init_sel   = 1'($urandom);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done_v[d]) break;
      end
      dg = dig_v[d];
   endtask

   initial begin
      logic [511:0] blk, blk2;
      logic [127:0] cv, dg, dg1, exp1, expd;
      logic         isel;
      int           lat, ndone;
      int           sweep [4] = '{0, 1, 3, 4};

      rst      = 1'b1;
      start_v  = '0;
      init_sel = 1'b0;
      block_in = '0;
      chain_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state of every core
      for (int d = 0; d < 5; d++) begin
         chk("rst_ready",  128'(ready_v[d]), 128'(1));
         chk("rst_busy",   128'(busy_v[d]),  128'(0));
         chk("rst_done",   128'(done_v[d]),  128'(0));
         chk("rst_digest", dig_v[d],         128'(0));
      end

      // MD4 of the empty message, S=1
      blk = '0;
      blk[31:0] = 32'h0000_0080;
      run_op(0, blk, 1'b1, '0, dg, lat);
      chk("empty_latency", 128'(lat), 128'(49));
      chk("empty_digest", dg, md4_ref(blk, IV));
      chk("empty_ready_with_done", 128'(ready_v[0]), 128'(1));
      @(negedge clk);
      chk("empty_done_one_cycle", 128'(done_v[0]), 128'(0));
      chk("empty_digest_held", dig_v[0], md4_ref(blk, IV));

      // MD4 of "abc", S=4
      blk = '0;
      blk[31:0]    = 32'h8063_6261;
      blk[479:448] = 32'h0000_0018;
      run_op(2, blk, 1'b1, '0, dg, lat);
      chk("abc_latency", 128'(lat), 128'(13));
      chk("abc_digest_const", dg, 128'h9d72a67a_e80ac15f_52d821af_7a0148a4);
      chk("abc_digest_model", dg, md4_ref(blk, IV));
      @(negedge clk);

      // Two-block message, S=1, second start issued in the done cycle
      blk  = rnd512();
      blk2 = rnd512();
      exp1 = md4_ref(blk, IV);
      run_op(0, blk, 1'b1, '0, dg1, lat);
      chk("blk1_latency", 128'(lat), 128'(49));
      chk("blk1_digest", dg1, exp1);
      run_op(0, blk2, 1'b0, dg1, dg, lat);
      chk("blk2_latency", 128'(lat), 128'(49));
      chk("blk2_digest", dg, md4_ref(blk2, exp1));
      @(negedge clk);

      // start held high with changing data during a run, S=2
      blk  = rnd512();
      cv   = {$urandom, $urandom, $urandom, $urandom};
      expd = md4_ref(blk, cv);
      chk("pulse_ready_at_start", 128'(ready_v[1]), 128'(1));
      block_in   = blk;
      chain_in   = cv;
      init_sel   = 1'b0;
      start_v[1] = 1'b1;
      @(posedge clk);
      lat = 0;
      while (lat < 200) begin
         #1;
         block_in = rnd512();
         chain_in = {$urandom, $urandom, $urandom, $urandom};
         init_sel = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done_v[1]) break;
      end
      start_v[1] = 1'b0;
      chk("pulse_latency", 128'(lat), 128'(25));
      chk("pulse_digest", dig_v[1], expd);
      ndone = 0;
      repeat (60) begin
         @(negedge clk);
         if (done_v[1]) ndone++;
      end
      chk("pulse_no_extra_done", 128'(ndone), 128'(0));
      chk("pulse_idle_after", 128'(busy_v[1]), 128'(0));

      // Reset in the middle of a run, S=1
      blk = '0;
      blk[31:0] = 32'h0000_0080;
      block_in   = blk;
      init_sel   = 1'b1;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("abort_busy_before", 128'(busy_v[0]), 128'(1));
      rst = 1'b1;
      #1;
      chk("abort_done",   128'(done_v[0]),  128'(0));
      chk("abort_digest", dig_v[0],         128'(0));
      chk("abort_busy",   128'(busy_v[0]),  128'(0));
      chk("abort_ready",  128'(ready_v[0]), 128'(1));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(0, blk, 1'b1, '0, dg, lat);
      chk("restart_latency", 128'(lat), 128'(49));
      chk("restart_digest", dg, md4_ref(blk, IV));
      @(negedge clk);

      // Random sweep over S = 1, 2, 8, 16
      foreach (sweep[n]) begin
         for (int it = 0; it < 100; it++) begin
            blk  = rnd512();
            cv   = {$urandom, $urandom, $urandom, $urandom};
            isel = 1'($urandom);
            expd = md4_ref(blk, isel ? IV : cv);
            run_op(sweep[n], blk, isel, cv, dg, lat);
            chk("sweep_latency", 128'(lat), 128'(48 / (1 << sweep[n]) + 1));
            chk("sweep_digest", dg, expd);
         end
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
